// File: rtl/cpu_pkg.sv
// Shared CPU pipeline definitions: forwarding select encodings and default widths.
package cpu_pkg;

  localparam int unsigned REG_AW_DEF  = 5;
  localparam int unsigned NUM_SRC_DEF = 2;
  localparam int unsigned CNT_W_DEF   = 16;

  typedef enum logic [1:0] {
    SEL_RF    = 2'b00,
    SEL_EXMEM = 2'b01,
    SEL_MEMWB = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/hazard_match.sv
// Per-source-slot hazard detection and forwarding select for one ID operand.
module hazard_match
  import cpu_pkg::*;
#(
  parameter int unsigned REG_AW = REG_AW_DEF
) (
  input  logic [REG_AW-1:0] src,
  input  logic              used,
  input  logic              branch,
  input  logic [REG_AW-1:0] ex_dst,
  input  logic              ex_wr,
  input  logic              ex_load,
  input  logic [REG_AW-1:0] mem_dst,
  input  logic              mem_wr,
  input  logic              mem_load,
  input  logic [REG_AW-1:0] wb_dst,
  input  logic              wb_wr,
  output logic              load_use,
  output logic              branch_haz,
  output fwd_sel_e          sel_id,
  output fwd_sel_e          sel_ex
);

  logic live;
  logic hit_ex;
  logic hit_mem;
  logic hit_wb;

  always_comb begin
    // $0 is hardwired, so it never creates a dependency
    live    = used && (src != '0);
    hit_ex  = live && ex_wr  && (src == ex_dst);
    hit_mem = live && mem_wr && (src == mem_dst);
    hit_wb  = live && wb_wr  && (src == wb_dst);

    load_use   = hit_ex && ex_load;
    branch_haz = branch && (hit_ex || (hit_mem && mem_load));

    sel_id = SEL_RF;
    if (branch) begin
      if (hit_mem && !mem_load) sel_id = SEL_EXMEM;
      else if (hit_wb)          sel_id = SEL_MEMWB;
    end

    sel_ex = SEL_RF;
    if (hit_ex && !ex_load) sel_ex = SEL_EXMEM;
    else if (hit_mem)       sel_ex = SEL_MEMWB;
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: stall/bubble generation, ID and EX forwarding selects,
// and a saturating stall-cycle counter.
module hazard_unit
  import cpu_pkg::*;
#(
  parameter int unsigned REG_AW  = REG_AW_DEF,
  parameter int unsigned NUM_SRC = NUM_SRC_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_SRC*REG_AW-1:0] id_src,
  input  logic [NUM_SRC-1:0]        id_src_used,
  input  logic                      id_branch,
  input  logic [REG_AW-1:0]         ex_dst,
  input  logic [REG_AW-1:0]         mem_dst,
  input  logic [REG_AW-1:0]         wb_dst,
  input  logic                      ex_wr,
  input  logic                      mem_wr,
  input  logic                      wb_wr,
  input  logic                      ex_load,
  input  logic                      mem_load,
  input  logic                      ex_busy,
  input  logic                      flush,
  output logic                      stall,
  output logic                      bubble,
  output logic [2*NUM_SRC-1:0]      fwd_id,
  output logic [2*NUM_SRC-1:0]      fwd_ex,
  output logic [CNT_W-1:0]          stall_cnt
);

  logic [NUM_SRC-1:0]   load_use;
  logic [NUM_SRC-1:0]   branch_haz;
  logic [2*NUM_SRC-1:0] fwd_ex_next;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_slot
    fwd_sel_e sel_id;
    fwd_sel_e sel_ex;

    hazard_match #(
      .REG_AW(REG_AW)
    ) u_match (
      .src        (id_src[g*REG_AW +: REG_AW]),
      .used       (id_src_used[g]),
      .branch     (id_branch),
      .ex_dst     (ex_dst),
      .ex_wr      (ex_wr),
      .ex_load    (ex_load),
      .mem_dst    (mem_dst),
      .mem_wr     (mem_wr),
      .mem_load   (mem_load),
      .wb_dst     (wb_dst),
      .wb_wr      (wb_wr),
      .load_use   (load_use[g]),
      .branch_haz (branch_haz[g]),
      .sel_id     (sel_id),
      .sel_ex     (sel_ex)
    );

    assign fwd_id[2*g +: 2]      = sel_id;
    assign fwd_ex_next[2*g +: 2] = sel_ex;
  end

  // A busy EX unit freezes ID/EX in place instead of inserting a NOP
  always_comb begin
    stall  = (|load_use) || (|branch_haz) || ex_busy;
    bubble = stall && !ex_busy;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                fwd_ex <= '0;
    else if (flush || bubble) fwd_ex <= '0;
    else if (!ex_busy)        fwd_ex <= fwd_ex_next;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                        stall_cnt <= '0;
    else if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: directed cycles push expectations, a negedge monitor checks.
module tb_hazard_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic [9:0]  id_src;
  logic [1:0]  id_src_used;
  logic        id_branch;
  logic [4:0]  ex_dst, mem_dst, wb_dst;
  logic        ex_wr, mem_wr, wb_wr, ex_load, mem_load, ex_busy, flush;
  logic        stall, bubble;
  logic [3:0]  fwd_id, fwd_ex;
  logic [15:0] stall_cnt;
  logic        stall4, bubble4;
  logic [3:0]  fwd_id4, fwd_ex4;
  logic [3:0]  stall_cnt4;

  always #5 clock = ~clock;

  hazard_unit #(.REG_AW(5), .NUM_SRC(2), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .id_src(id_src), .id_src_used(id_src_used),
    .id_branch(id_branch), .ex_dst(ex_dst), .mem_dst(mem_dst), .wb_dst(wb_dst),
    .ex_wr(ex_wr), .mem_wr(mem_wr), .wb_wr(wb_wr), .ex_load(ex_load),
    .mem_load(mem_load), .ex_busy(ex_busy), .flush(flush), .stall(stall),
    .bubble(bubble), .fwd_id(fwd_id), .fwd_ex(fwd_ex), .stall_cnt(stall_cnt)
  );

  hazard_unit #(.REG_AW(5), .NUM_SRC(2), .CNT_W(4)) dut4 (
    .clock(clock), .reset(reset), .id_src(id_src), .id_src_used(id_src_used),
    .id_branch(id_branch), .ex_dst(ex_dst), .mem_dst(mem_dst), .wb_dst(wb_dst),
    .ex_wr(ex_wr), .mem_wr(mem_wr), .wb_wr(wb_wr), .ex_load(ex_load),
    .mem_load(mem_load), .ex_busy(ex_busy), .flush(flush), .stall(stall4),
    .bubble(bubble4), .fwd_id(fwd_id4), .fwd_ex(fwd_ex4), .stall_cnt(stall_cnt4)
  );

  typedef struct {
    logic        st;
    logic        bu;
    logic [3:0]  fid;
    logic [3:0]  fex;
    logic [15:0] cnt;
    logic [3:0]  cnt4;
  } exp_t;

  exp_t sb[$];
  int unsigned total  = 0;
  int unsigned passed = 0;
  logic [15:0] m_cnt  = '0;
  logic [3:0]  m_cnt4 = '0;

  task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clock) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      cmp("stall",      16'(stall),      16'(e.st));
      cmp("bubble",     16'(bubble),     16'(e.bu));
      cmp("fwd_id",     16'(fwd_id),     16'(e.fid));
      cmp("fwd_ex",     16'(fwd_ex),     16'(e.fex));
      cmp("stall_cnt",  stall_cnt,       e.cnt);
      cmp("stall_cnt4", 16'(stall_cnt4), 16'(e.cnt4));
    end
  end

  // Counter expectations follow the hand-written stall values of earlier cycles
  task automatic chk(input logic st, input logic bu, input logic [3:0] fid, input logic [3:0] fex);
    exp_t e;
    e.st = st; e.bu = bu; e.fid = fid; e.fex = fex;
    if (reset) begin
      m_cnt = '0; m_cnt4 = '0;
    end
    e.cnt = m_cnt; e.cnt4 = m_cnt4;
    sb.push_back(e);
    if (!reset && st) begin
      if (m_cnt  != '1) m_cnt  = m_cnt + 16'd1;
      if (m_cnt4 != '1) m_cnt4 = m_cnt4 + 4'd1;
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
    id_src = '0; id_src_used = '0; id_branch = 0;
    ex_dst = '0; mem_dst = '0; wb_dst = '0;
    ex_wr = 0; mem_wr = 0; wb_wr = 0; ex_load = 0; mem_load = 0;
    ex_busy = 0; flush = 0;
  endtask

  initial begin
    reset = 1'b1;
    next_cycle();
    id_src[4:0] = 5'd8; id_src_used = 2'b01; ex_load = 1; ex_wr = 1; ex_dst = 5'd8;
    chk(1, 1, 4'b0000, 4'b0000);
    next_cycle(); reset = 1'b0;
    chk(0, 0, 4'b0000, 4'b0000);
    // ALU result forwarded to EX on slot1
    next_cycle(); ex_wr = 1; ex_dst = 5'd3; id_src[9:5] = 5'd3; id_src_used = 2'b10;
    chk(0, 0, 4'b0000, 4'b0000);
    next_cycle();
    chk(0, 0, 4'b0000, 4'b0100);
    // load-use stall then MEM/WB forward
    next_cycle(); ex_load = 1; ex_wr = 1; ex_dst = 5'd8; id_src[4:0] = 5'd8; id_src_used = 2'b01;
    chk(1, 1, 4'b0000, 4'b0000);
    next_cycle(); mem_load = 1; mem_wr = 1; mem_dst = 5'd8; id_src[4:0] = 5'd8; id_src_used = 2'b01;
    chk(0, 0, 4'b0000, 4'b0000);
    next_cycle();
    chk(0, 0, 4'b0000, 4'b0010);
    // $0 never matches
    next_cycle(); id_branch = 1; id_src_used = 2'b01; ex_wr = 1; ex_load = 1; ex_dst = 5'd0;
    chk(0, 0, 4'b0000, 4'b0000);
    // branch after load: two stall cycles, then WB forward into ID
    next_cycle(); id_branch = 1; id_src[4:0] = 5'd5; id_src_used = 2'b01; ex_load = 1; ex_wr = 1; ex_dst = 5'd5;
    chk(1, 1, 4'b0000, 4'b0000);
    next_cycle(); id_branch = 1; id_src[4:0] = 5'd5; id_src_used = 2'b01; mem_load = 1; mem_wr = 1; mem_dst = 5'd5;
    chk(1, 1, 4'b0000, 4'b0000);
    next_cycle(); id_branch = 1; id_src[4:0] = 5'd5; id_src_used = 2'b01; wb_wr = 1; wb_dst = 5'd5;
    chk(0, 0, 4'b0010, 4'b0000);
    next_cycle(); id_branch = 1; id_src[9:5] = 5'd7; id_src_used = 2'b10; mem_wr = 1; mem_dst = 5'd7;
    chk(0, 0, 4'b0100, 4'b0000);
    next_cycle(); id_branch = 1; id_src[4:0] = 5'd9; id_src_used = 2'b01; ex_wr = 1; ex_dst = 5'd9;
    chk(1, 1, 4'b0000, 4'b1000);
    // EX beats MEM on both slots
    next_cycle(); id_src = {5'd4, 5'd4}; id_src_used = 2'b11; ex_wr = 1; ex_dst = 5'd4; mem_wr = 1; mem_dst = 5'd4;
    chk(0, 0, 4'b0000, 4'b0000);
    next_cycle(); flush = 1; id_src[4:0] = 5'd6; id_src_used = 2'b01; ex_wr = 1; ex_dst = 5'd6;
    chk(0, 0, 4'b0000, 4'b0101);
    next_cycle();
    chk(0, 0, 4'b0000, 4'b0000);
    // flush wins over busy-hold
    next_cycle(); id_src[4:0] = 5'd2; id_src_used = 2'b01; ex_wr = 1; ex_dst = 5'd2;
    chk(0, 0, 4'b0000, 4'b0000);
    next_cycle(); flush = 1; ex_busy = 1;
    chk(1, 0, 4'b0000, 4'b0001);
    next_cycle(); id_src[4:0] = 5'd2; id_src_used = 2'b01; ex_wr = 1; ex_dst = 5'd2;
    chk(0, 0, 4'b0000, 4'b0000);
    for (int i = 0; i < 4; i++) begin
      next_cycle(); ex_busy = 1; id_src[9:5] = 5'd3; id_src_used = 2'b10; mem_wr = 1; mem_dst = 5'd3;
      chk(1, 0, 4'b0000, 4'b0001);
    end
    next_cycle();
    chk(0, 0, 4'b0000, 4'b0001);
    next_cycle();
    chk(0, 0, 4'b0000, 4'b0000);
    // drive the 4-bit counter into saturation
    for (int i = 0; i < 8; i++) begin
      next_cycle(); ex_busy = 1;
      chk(1, 0, 4'b0000, 4'b0000);
    end
    next_cycle();
    chk(0, 0, 4'b0000, 4'b0000);
    // reset arriving during a load-use stall with a forward pending
    next_cycle(); id_src[4:0] = 5'd4; id_src_used = 2'b01; ex_wr = 1; ex_dst = 5'd4;
    chk(0, 0, 4'b0000, 4'b0000);
    next_cycle(); reset = 1'b1; ex_load = 1; ex_wr = 1; ex_dst = 5'd8; id_src[4:0] = 5'd8; id_src_used = 2'b01;
    chk(1, 1, 4'b0000, 4'b0000);
    next_cycle(); reset = 1'b0; ex_load = 1; ex_wr = 1; ex_dst = 5'd8; id_src[4:0] = 5'd8; id_src_used = 2'b01;
    chk(1, 1, 4'b0000, 4'b0000);
    next_cycle();
    chk(0, 0, 4'b0000, 4'b0000);
    // non-branch WB match gets no ID forward
    next_cycle(); id_src[4:0] = 5'd5; id_src_used = 2'b01; wb_wr = 1; wb_dst = 5'd5; mem_wr = 1; mem_dst = 5'd5;
    chk(0, 0, 4'b0000, 4'b0000);
    next_cycle();
    chk(0, 0, 4'b0000, 4'b0010);

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clock);
    #1;
    if (sb.size() != 0) begin
      total++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 Parameters: REG_AW, default 5, register address width; NUM_SRC, default 2, source operands per instruction; CNT_W, default 16, stall counter width.
REQ-002 One clock; reset is asynchronous and active-high.
REQ-003 clock  in  1  pipeline clock; all state changes on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 id_src  in  NUM_SRC*REG_AW  ID-stage source register addresses; slot i occupies bits [i*REG_AW +: REG_AW].
REQ-006 id_src_used  in  NUM_SRC  per-slot flag: slot is actually read.
REQ-007 id_branch  in  1  ID instruction is a branch compared in ID.
REQ-008 ex_dst, mem_dst, wb_dst  in  REG_AW each  destination register of the EX, MEM and WB stages.
REQ-009 ex_wr, mem_wr, wb_wr  in  1 each  stage writes the register file.
REQ-010 ex_load, mem_load  in  1 each  stage holds a memory load.
REQ-011 ex_busy  in  1  multi-cycle EX unit not finished.
REQ-012 flush  in  1  taken branch/jump; squash IF/ID.
REQ-013 stall  out  1  freeze PC and IF/ID.
REQ-014 bubble  out  1  load NOP into ID/EX.
REQ-015 fwd_id  out  2*NUM_SRC  combinational ID-compare select per slot.
REQ-016 fwd_ex  out  2*NUM_SRC  registered EX operand select per slot.
REQ-017 stall_cnt  out  CNT_W  saturating count of stall cycles.

Function
REQ-018 Select encoding for both fwd_id and fwd_ex: 00 register file, 01 EX/MEM result, 10 MEM/WB result; 11 is never driven.
REQ-019 Match(slot, stage) is true only if id_src_used[i], stage write flag is 1, address equal and address != 0.
REQ-020 Load-use hazard: any slot matches EX with ex_load=1 -> stall for that cycle.
REQ-021 Branch hazard (id_branch=1): match EX (load or not) -> stall; match MEM with mem_load=1 -> stall; so a branch after a load stalls 2 cycles and after an ALU op 1 cycle.
REQ-022 ex_busy=1 -> stall=1 and bubble=0 (ID/EX holds); otherwise bubble = stall.
REQ-023 stall is combinational from current inputs; no added latency.
REQ-024 fwd_id[i] (only when id_branch=1, else 00): MEM match with mem_load=0 -> 01; else WB match -> 10; else 00.
REQ-025 fwd_ex next value per slot, computed in ID: EX match with ex_load=0 -> 01; else MEM match -> 10; else 00; EX has priority over MEM.
REQ-026 fwd_ex update: flush=1 or bubble=1 -> all 00; ex_busy=1 -> hold; else load next value; flush has priority over hold.
REQ-027 stall_cnt increments by 1 every cycle stall=1; holds at all-ones (saturation, no wrap).
REQ-028 flush and stall in the same cycle: stall, bubble still driven per REQ-020..022; fwd_ex cleared.
REQ-029 WB-to-ID same-cycle register read relies on register-file write-through; for non-branch slots no ID forwarding is generated.

Reset
REQ-030 While reset=1: fwd_ex=0, stall_cnt=0; stall, bubble, fwd_id follow inputs combinationally.
REQ-031 Reset deassertion mid-stall: first post-reset edge behaves as normal operation; no pending state retained.

Structure
REQ-032 Select encodings (SEL_RF, SEL_EXMEM, SEL_MEMWB) and default parameter values live in shared package cpu_pkg.
REQ-033 One sub-module, hazard_match, computes per-slot match/select for one source slot; instantiated NUM_SRC times via generate.

Verification
REQ-034 EX: lw $8 (ex_load=1, ex_dst=8); ID: add using $8 -> stall=1, bubble=1 one cycle; next cycle (mem_dst=8) fwd_ex slot0 = 10 after edge.
REQ-035 EX: add $3 (ex_wr=1); ID: sub using $3 in slot1 -> no stall; after edge fwd_ex slot1 = 01.
REQ-036 Branch in ID comparing $5, EX lw $5 -> stall 2 consecutive cycles, then fwd_id = 10 with $5 in WB; stall_cnt +2.
REQ-037 Source $0 with ex_dst=0, ex_wr=1 -> no stall, fwd 00.
REQ-038 ex_busy=1 for 4 cycles -> stall=1, bubble=0, fwd_ex held; stall_cnt +4; with CNT_W=4 preloaded to 15, stays 15.
REQ-039 reset asserted during load-use stall -> fwd_ex=0, stall_cnt=0 immediately; flush with pending forward clears fwd_ex.
